// File: rtl/prescaler_multi_if.sv
// prescaler_multi_if
//   Bundles the control, divisor-write and output signals of the multi-channel
//   prescaler so that the block connects to its controller through one port.
//   master : controller side, drives enables/sync/writes and observes outputs
//   slave  : prescaler side
//   Signals:
//     ch_en   [NUM_CH]  per-channel run enable
//     sync              restart all channels in phase
//     wr_en             divisor write strobe (one cycle)
//     wr_ch   [CH_W]    target channel of the write
//     wr_div  [DIV_W]   new divisor value
//     tick    [NUM_CH]  one-cycle strobe per channel period
//     clk_out [NUM_CH]  50% duty square output, period 2*div
//     pend    [NUM_CH]  written divisor not yet applied
interface prescaler_multi_if #(
  parameter int NUM_CH = 4,
  parameter int DIV_W  = 24
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH-1:0] ch_en;
  logic              sync;
  logic              wr_en;
  logic [CH_W-1:0]   wr_ch;
  logic [DIV_W-1:0]  wr_div;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] clk_out;
  logic [NUM_CH-1:0] pend;

  modport master (
    output ch_en, sync, wr_en, wr_ch, wr_div,
    input  tick, clk_out, pend
  );

  modport slave (
    input  ch_en, sync, wr_en, wr_ch, wr_div,
    output tick, clk_out, pend
  );
endinterface

// File: rtl/prescaler_multi.sv
// prescaler_multi
//   Multi-channel programmable clock prescaler for the LED timing path.
//   Every channel divides clk by a run-time programmable divisor d and gives
//   a one-cycle tick every d cycles plus a 50% duty square wave of period 2*d.
//   Divisor writes are held pending until the running period completes, so
//   a change never truncates or stretches a period.
//   Ports:
//     clk  system clock, rising edge
//     rst  asynchronous active-high reset
//     bus  prescaler_multi_if.slave (ch_en, sync, wr_en, wr_ch, wr_div in;
//          tick, clk_out, pend out)
module prescaler_multi #(
  parameter int NUM_CH      = 4,
  parameter int DIV_W       = 24,
  parameter int DEFAULT_DIV = 50000
) (
  input  logic                   clk,
  input  logic                   rst,
  prescaler_multi_if.slave       bus
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [DIV_W-1:0] DEF_DIV = DIV_W'(DEFAULT_DIV);

  logic [DIV_W-1:0]  cnt      [NUM_CH];
  logic [DIV_W-1:0]  div_act  [NUM_CH];
  logic [DIV_W-1:0]  div_pend [NUM_CH];
  logic [DIV_W-1:0]  term_val [NUM_CH];
  logic [NUM_CH-1:0] tick_q;
  logic [NUM_CH-1:0] clk_q;
  logic [NUM_CH-1:0] pend_q;
  logic [NUM_CH-1:0] tc;
  logic [NUM_CH-1:0] apply;
  logic [NUM_CH-1:0] wr_hit;
  logic              wr_valid;

  // Per-channel decode of the terminal count and of the edges where a new
  // divisor may take effect. A divisor of zero is treated as one, so the
  // terminal value collapses to zero in both cases. Divisor changes are only
  // allowed at a period boundary (terminal count), while the channel is held
  // idle, or on a sync restart -- those are the points where no period is
  // in flight and swapping d cannot produce a short or long pulse.
  always_comb begin
    wr_valid = bus.wr_en && (int'(bus.wr_ch) < NUM_CH);
    for (int i = 0; i < NUM_CH; i++) begin
      term_val[i] = (div_act[i] == '0) ? '0 : div_act[i] - DIV_W'(1);
      tc[i]       = bus.ch_en[i] && (cnt[i] == term_val[i]);
      apply[i]    = bus.sync || !bus.ch_en[i] || tc[i];
      wr_hit[i]   = wr_valid && (bus.wr_ch == CH_W'(i));
    end
  end

  // Channel state. The counter/output part follows the priority
  // sync > disabled > terminal count > count. The divisor part runs
  // alongside it: on an apply edge a write landing in the same cycle goes
  // straight into the active divisor (newest value wins), otherwise any
  // pending divisor is promoted; on other edges a write only parks the value
  // in div_pend and raises pend, overwriting any earlier pending value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt[i]      <= '0;
        div_act[i]  <= DEF_DIV;
        div_pend[i] <= DEF_DIV;
      end
      tick_q <= '0;
      clk_q  <= '0;
      pend_q <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (bus.sync || !bus.ch_en[i]) begin
          cnt[i]    <= '0;
          tick_q[i] <= 1'b0;
          clk_q[i]  <= 1'b0;
        end else if (tc[i]) begin
          cnt[i]    <= '0;
          tick_q[i] <= 1'b1;
          clk_q[i]  <= ~clk_q[i];
        end else begin
          cnt[i]    <= cnt[i] + DIV_W'(1);
          tick_q[i] <= 1'b0;
        end

        if (apply[i]) begin
          if (wr_hit[i]) begin
            div_act[i] <= bus.wr_div;
            pend_q[i]  <= 1'b0;
          end else if (pend_q[i]) begin
            div_act[i] <= div_pend[i];
            pend_q[i]  <= 1'b0;
          end
        end else if (wr_hit[i]) begin
          div_pend[i] <= bus.wr_div;
          pend_q[i]   <= 1'b1;
        end
      end
    end
  end

  // Outputs come straight from registers so downstream logic sees
  // glitch-free strobes and clocks.
  assign bus.tick    = tick_q;
  assign bus.clk_out = clk_q;
  assign bus.pend    = pend_q;

endmodule

// File: tb/tb_prescaler_multi.sv
// tb_prescaler_multi
//   Directed self-checking bench for prescaler_multi with three channels,
//   16-bit divisors and a reset divisor of 4. Expected waveforms are written
//   as hand-computed bit vectors (bit k = cycle k+1 of the capture window).
module tb_prescaler_multi;
  localparam int NUM_CH = 3;
  localparam int DIV_W  = 16;

  logic clk;
  logic rst;

  int checks;
  int failures;

  logic [31:0] tick_log [NUM_CH];
  logic [31:0] clk_log  [NUM_CH];
  logic [31:0] pend_log [NUM_CH];

  prescaler_multi_if #(.NUM_CH(NUM_CH), .DIV_W(DIV_W)) bus ();

  prescaler_multi #(
    .NUM_CH(NUM_CH),
    .DIV_W(DIV_W),
    .DEFAULT_DIV(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Free-running 100 MHz clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance n clock edges, stopping just after the last one.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One-cycle divisor write; returns just after the write edge.
  task automatic applyStimulus(input logic [1:0] ch, input logic [DIV_W-1:0] div);
    bus.wr_en  = 1'b1;
    bus.wr_ch  = ch;
    bus.wr_div = div;
    step(1);
    bus.wr_en  = 1'b0;
  endtask

  // Record tick/clk_out/pend of every channel for n cycles.
  task automatic capture(input int n);
    for (int c = 0; c < NUM_CH; c++) begin
      tick_log[c] = '0;
      clk_log[c]  = '0;
      pend_log[c] = '0;
    end
    for (int k = 0; k < n; k++) begin
      step(1);
      for (int c = 0; c < NUM_CH; c++) begin
        tick_log[c][k] = bus.tick[c];
        clk_log[c][k]  = bus.clk_out[c];
        pend_log[c][k] = bus.pend[c];
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst        = 1'b1;
    bus.ch_en  = 3'b001;
    bus.sync   = 1'b0;
    bus.wr_en  = 1'b0;
    bus.wr_ch  = '0;
    bus.wr_div = '0;

    // Reset state and default divisor of 4 on ch0.
    step(2);
    checkOutput("rst_tick", 32'(bus.tick), 32'h0);
    checkOutput("rst_clk",  32'(bus.clk_out), 32'h0);
    checkOutput("rst_pend", 32'(bus.pend), 32'h0);
    rst = 1'b0;
    capture(16);
    checkOutput("t1_tick", tick_log[0], 32'h8888);
    checkOutput("t1_clk",  clk_log[0],  32'h7878);

    // Divisor 0 and 1 written while disabled both act as divide-by-1.
    bus.ch_en[0] = 1'b0;
    step(1);
    applyStimulus(2'd0, 16'd0);
    checkOutput("t2_d0_pend", 32'(bus.pend[0]), 32'h0);
    bus.ch_en[0] = 1'b1;
    capture(6);
    checkOutput("t2_d0_tick", tick_log[0], 32'h3F);
    checkOutput("t2_d0_clk",  clk_log[0],  32'h15);
    bus.ch_en[0] = 1'b0;
    applyStimulus(2'd0, 16'd1);
    checkOutput("t2_d1_pend", 32'(bus.pend[0]), 32'h0);
    bus.ch_en[0] = 1'b1;
    capture(6);
    checkOutput("t2_d1_tick", tick_log[0], 32'h3F);
    checkOutput("t2_d1_clk",  clk_log[0],  32'h15);

    // d=10, write 3 at cnt=2: period completes at 10, then every 3.
    bus.ch_en[0] = 1'b0;
    applyStimulus(2'd0, 16'd10);
    bus.ch_en[0] = 1'b1;
    step(2);
    applyStimulus(2'd0, 16'd3);
    checkOutput("t3_pend_set", 32'(bus.pend[0]), 32'h1);
    capture(16);
    checkOutput("t3_tick", tick_log[0], 32'h9240);
    checkOutput("t3_pend", pend_log[0], 32'h003F);

    // Write 7 to ch1 exactly on its terminal-count edge.
    bus.ch_en[1] = 1'b1;
    step(3);
    applyStimulus(2'd1, 16'd7);
    checkOutput("t4_tc_tick", 32'(bus.tick[1]), 32'h1);
    checkOutput("t4_tc_pend", 32'(bus.pend[1]), 32'h0);
    capture(8);
    checkOutput("t4_tick", tick_log[1], 32'h40);
    checkOutput("t4_pend", pend_log[1], 32'h0);

    // ch0 d=5, ch1 d=3 out of phase, then sync.
    bus.ch_en = 3'b000;
    applyStimulus(2'd0, 16'd5);
    applyStimulus(2'd1, 16'd3);
    bus.ch_en[0] = 1'b1;
    step(2);
    bus.ch_en[1] = 1'b1;
    step(4);
    bus.sync = 1'b1;
    step(1);
    bus.sync = 1'b0;
    checkOutput("t5_sync_tick", 32'(bus.tick[1:0]), 32'h0);
    checkOutput("t5_sync_clk",  32'(bus.clk_out[1:0]), 32'h0);
    capture(15);
    checkOutput("t5_tick0", tick_log[0], 32'h4210);
    checkOutput("t5_tick1", tick_log[1], 32'h4924);
    checkOutput("t5_coinc", tick_log[0] & tick_log[1], 32'h4000);
    applyStimulus(2'd3, 16'd9);
    checkOutput("t5_bad_ch_pend", 32'(bus.pend), 32'h0);
    capture(15);
    checkOutput("t5_after_tick0", tick_log[0], 32'h2108);
    checkOutput("t5_after_tick1", tick_log[1], 32'h2492);

    // Reset mid-period with a pending write on ch0.
    applyStimulus(2'd0, 16'd2);
    step(1);
    checkOutput("t6_pre_pend", 32'(bus.pend), 32'h1);
    checkOutput("t6_pre_ch1",  32'({bus.tick[1], bus.clk_out[1]}), 32'h3);
    #2 rst = 1'b1;
    #1;
    checkOutput("t6_async", 32'({bus.tick, bus.clk_out, bus.pend}), 32'h0);
    step(2);
    rst = 1'b0;
    capture(8);
    checkOutput("t6_tick0", tick_log[0], 32'h88);
    checkOutput("t6_tick1", tick_log[1], 32'h88);
    checkOutput("t6_pend0", pend_log[0], 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
